// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline write-enable/flush/bubble control with HLT drain FSM
// Optional performance counters: define STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_en,
  input  logic             branch_taken,
  input  logic             dec_halt,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             halted,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_drain_cnt;

  // HLT only leaves ID when neither a memory freeze nor a load-use stall holds it back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!dmem_busy && !stall_en && dec_halt) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          if (!dmem_busy) begin
            if (r_drain_cnt == '0) begin
              r_state <= S_HALTED;
            end else begin
              r_drain_cnt <= r_drain_cnt - 1'b1;
            end
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    halted       = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_RUN: begin
          if (dmem_busy) begin
            pc_we = 1'b0;
          end else if (stall_en) begin
            id_ex_we     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_we    = 1'b1;
            mem_wb_we    = 1'b1;
          end else if (dec_halt) begin
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
          end else if (branch_taken) begin
            // The redirect wins over a pending fetch, so the PC still loads.
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
          end else if (imem_busy) begin
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
          end
        end
        S_DRAIN: begin
          if (!dmem_busy) begin
            id_ex_we     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_we    = 1'b1;
            mem_wb_we    = 1'b1;
          end
        end
        S_HALTED: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_mem_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt  <= '0;
      r_mem_cnt <= '0;
    end else begin
      if ((r_state == S_RUN) && stall_en && !dmem_busy && (r_lu_cnt != '1)) begin
        r_lu_cnt <= r_lu_cnt + 1'b1;
      end
      if ((r_state != S_HALTED) && dmem_busy && (r_mem_cnt != '1)) begin
        r_mem_cnt <= r_mem_cnt + 1'b1;
      end
    end
  end

  assign lu_stall_cnt  = r_lu_cnt;
  assign mem_stall_cnt = r_mem_cnt;
`else
  assign lu_stall_cnt  = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed vector bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_en = 1'b0, branch_taken = 1'b0, dec_halt = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0;
  logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we, halted;
  logic [CW-1:0] lu_stall_cnt, mem_stall_cnt;
  logic [7:0] w_outs;

  int checks = 0;
  int errors = 0;

  pipeline_stall_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_en(stall_en), .branch_taken(branch_taken),
    .dec_halt(dec_halt), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
    .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .halted(halted), .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
  );

  always #5 clk = ~clk;

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we, halted}
  assign w_outs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we, halted};

  localparam logic [7:0] O_NONE   = 8'b0000_0000;
  localparam logic [7:0] O_NORMAL = 8'b1101_0110;
  localparam logic [7:0] O_STALL  = 8'b0001_1110;
  localparam logic [7:0] O_HLT    = 8'b0001_0110;
  localparam logic [7:0] O_BRANCH = 8'b1111_0110;
  localparam logic [7:0] O_IMEM   = 8'b0111_0110;
  localparam logic [7:0] O_HALTED = 8'b0000_0001;

  typedef struct {
    string      name;
    logic [4:0] ins;   // {stall, branch, halt, imem, dmem}
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
  task automatic apply(input logic [4:0] ins);
    @(negedge clk);
    {stall_en, branch_taken, dec_halt, imem_busy, dmem_busy} = ins;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {stall_en, branch_taken, dec_halt, imem_busy, dmem_busy} = 5'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [CW-1:0] exp_cnt(input logic [CW-1:0] v);
`ifdef STALL_PERF_CNT_EN
    return v;
`else
    return '0 & v;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"idle",          5'b00000, O_NORMAL};
    vecs[1] = '{"dmem_all",      5'b11111, O_NONE};
    vecs[2] = '{"stall_branch",  5'b11000, O_STALL};
    vecs[3] = '{"stall_halt",    5'b10100, O_STALL};
    vecs[4] = '{"branch",        5'b01000, O_BRANCH};
    vecs[5] = '{"branch_imem",   5'b01010, O_BRANCH};
    vecs[6] = '{"imem",          5'b00010, O_IMEM};
    vecs[7] = '{"dmem_only",     5'b00001, O_NONE};

    // Reset state, with inputs that would otherwise enable everything.
    #3;
    chk("reset_outs", w_outs, O_NONE);
    chk_cnt("reset_lu", lu_stall_cnt, '0);
    chk_cnt("reset_mem", mem_stall_cnt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("release_idle", w_outs, O_NORMAL);
    apply(5'b00000);
    chk("run_idle", w_outs, O_NORMAL);
    rst_n = 1'b0;
    #1;
    chk("async_reset", w_outs, O_NONE);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].ins);
      chk(vecs[i].name, w_outs, vecs[i].exp);
    end

    // Stall masks a same-cycle branch; the branch is taken the following cycle.
    do_reset();
    apply(5'b11000);
    chk("seq_stall_br", w_outs, O_STALL);
    apply(5'b01000);
    chk("seq_br_after", w_outs, O_BRANCH);

    // Memory freeze over a load-use stall for three cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(5'b10001);
      chk($sformatf("freeze_%0d", i), w_outs, O_NONE);
    end
    apply(5'b00000);
    chk_cnt("freeze_mem_cnt", mem_stall_cnt, exp_cnt(4'd3));
    chk_cnt("freeze_lu_cnt", lu_stall_cnt, '0);

    // HLT drain with a frozen cycle and ignored stall pulses.
    do_reset();
    apply(5'b00100);
    chk("hlt_N", w_outs, O_HLT);
    apply(5'b10000);
    chk("hlt_N1", w_outs, O_STALL);
    apply(5'b00001);
    chk("hlt_N2_frz", w_outs, O_NONE);
    apply(5'b10000);
    chk("hlt_N3", w_outs, O_STALL);
    apply(5'b00000);
    chk("hlt_N4", w_outs, O_STALL);
    apply(5'b00000);
    chk("hlt_N5", w_outs, O_HALTED);
    apply(5'b11110);
    chk("hlt_N6", w_outs, O_HALTED);
    apply(5'b00001);
    chk("hlt_N7", w_outs, O_HALTED);
    chk_cnt("hlt_lu_cnt", lu_stall_cnt, '0);
    chk_cnt("hlt_mem_cnt", mem_stall_cnt, exp_cnt(4'd1));

    // Redirect during a pending fetch, then the fetch alone.
    do_reset();
    apply(5'b01010);
    chk("imem_br", w_outs, O_BRANCH);
    apply(5'b00010);
    chk("imem_only", w_outs, O_IMEM);

    // Load-use counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(5'b10000);
    end
    apply(5'b00000);
    chk_cnt("lu_saturate", lu_stall_cnt, exp_cnt(4'hF));
    chk("after_stalls", w_outs, O_NORMAL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer side of the load-use stall request. Takes stall_en from the hazard detection unit, plus branch, halt and memory-busy events.
- Drives the per-stage pipeline register write enables, the IF/ID flush and the ID/EX bubble for the 5-stage WISC pipeline.
- Owns the halt drain sequence: HLT retires through EX/MEM/WB before the halted flag rises.
- Sits beside the hazard unit in the top-level CPU; all pipeline registers take their enables from this block.

Parameters:
- DRAIN_CYCLES, 3, cycles after HLT leaves ID before halted asserts (EX, MEM, WB).
- CNT_W, 16, width of the performance counters under the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_en  input  1  load-use stall request from the hazard detection unit.
- branch_taken  input  1  branch/jump resolved taken in ID this cycle.
- dec_halt  input  1  ID instruction is HLT (opcode 4'b1111).
- imem_busy  input  1  instruction memory has not returned the fetch.
- dmem_busy  input  1  data memory access in MEM is not complete.
- pc_we  output  1  PC register write enable.
- if_id_we  output  1  IF/ID write enable.
- if_id_flush  output  1  IF/ID loads NOP.
- id_ex_we  output  1  ID/EX write enable.
- id_ex_bubble  output  1  ID/EX loads NOP (control bits zeroed).
- ex_mem_we  output  1  EX/MEM write enable.
- mem_wb_we  output  1  MEM/WB write enable.
- halted  output  1  pipeline drained after HLT.
- lu_stall_cnt  output  CNT_W  load-use stall cycles (optional feature).
- mem_stall_cnt  output  CNT_W  dmem_busy freeze cycles (optional feature).

Behaviour:
- Reset:
  - Clock is clk. Reset is rst_n, asynchronous and active-low.
  - While rst_n=0: every *_we, if_id_flush, id_ex_bubble and halted is 0; counters are 0; state is RUN.
  - Outputs gate on rst_n, so a deassertion mid-cycle takes effect combinationally.
- FSM states: RUN, DRAIN, HALTED. Registered state; outputs are combinational from state and inputs, with zero latency.
- RUN, evaluated in this priority order (first match wins):
  - dmem_busy=1: full freeze. All five *_we=0, flush=0, bubble=0.
  - stall_en=1: pc_we=0, if_id_we=0, id_ex_we=1 with id_ex_bubble=1, ex_mem_we=1, mem_wb_we=1. branch_taken and dec_halt are ignored this cycle and re-evaluated next cycle, because the instruction stays in ID.
  - dec_halt=1: pc_we=0, if_id_we=0, id_ex_we=1 with no bubble (HLT advances), later stages enabled. Next state is DRAIN and the drain counter loads DRAIN_CYCLES-1.
  - branch_taken=1: all we=1 and if_id_flush=1. If imem_busy=1 at the same time, pc_we stays 1, because the redirect overrides the pending fetch.
  - imem_busy=1: pc_we=0, if_id_we=1 with if_id_flush=1, ID/EX onward enabled.
  - Otherwise all we=1 and flush/bubble=0.
- DRAIN:
  - pc_we=0, if_id_we=0, id_ex_we=1 with id_ex_bubble=1, ex_mem_we=1, mem_wb_we=1.
  - stall_en, branch_taken, dec_halt and imem_busy are ignored.
  - dmem_busy=1 freezes all stages and holds the counter.
  - Otherwise the counter decrements. When the counter is 0 and dmem_busy=0, next state is HALTED.
- HALTED:
  - All *_we=0, flush/bubble=0, halted=1.
  - Stays in HALTED until rst_n=0.
- DRAIN_CYCLES=1: DRAIN lasts exactly one non-frozen cycle.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - lu_stall_cnt increments on each RUN cycle where stall_en=1 and dmem_busy=0.
  - mem_stall_cnt increments on each cycle where state≠HALTED and dmem_busy=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports still exist, are tied to 0, and no counter flops are built.

Test Plan:
- Reset, then release with all inputs 0: all *_we=1, flush=0, bubble=0, halted=0. Assert rst_n=0 mid-run: all outputs return to 0 asynchronously, before the next edge.
- stall_en=1 for 1 cycle with branch_taken=1 in the same cycle: pc_we=0, if_id_we=0, id_ex_bubble=1, if_id_flush=0. Next cycle branch_taken=1, stall_en=0: if_id_flush=1, pc_we=1.
- dmem_busy=1 for 3 cycles while stall_en=1: all *_we=0 for 3 cycles, bubble=0. With STALL_PERF_CNT_EN defined: mem_stall_cnt=3 and lu_stall_cnt=0.
- dec_halt=1 at cycle N (DRAIN_CYCLES=3), dmem_busy=1 at N+2: HALTED is reached at the edge ending cycle N+4 and halted=1 from cycle N+5. All we=0 thereafter. stall_en pulses after N are ignored.
- imem_busy=1 and branch_taken=1 together, then imem_busy alone: first cycle pc_we=1 with if_id_flush=1; second cycle pc_we=0 with if_id_flush=1, if_id_we=1, id_ex_we=1.
- With STALL_PERF_CNT_EN and CNT_W=4: 20 consecutive stall_en cycles give lu_stall_cnt saturated at 4'hF.
